// File: rtl/timer_pkg.sv
// Shared types and elaboration helpers for the multi-channel timer bank.
package timer_pkg;

  typedef enum logic {CH_IDLE = 1'b0, CH_RUN = 1'b1} chan_state_e;
  typedef enum logic {MODE_PERIODIC = 1'b0, MODE_ONESHOT = 1'b1} timer_mode_e;

  // Prescaler divide ratio; 0 flags an unusable clock/tick pair.
  function automatic int calc_div(input int clk_hz, input int tick_hz);
    if (tick_hz <= 0 || clk_hz < tick_hz) return 0;
    if ((clk_hz % tick_hz) != 0) return 0;
    return clk_hz / tick_hz;
  endfunction

endpackage

// File: rtl/timer_bank_if.sv
// Config/control and status bundle between a timer bank and its user.
interface timer_bank_if
  import timer_pkg::*;
#(
  parameter int P_CHANNELS = 4,
  parameter int P_WIDTH    = 16
);
  localparam int CH_W = $clog2(P_CHANNELS);

  logic                  wr_en;
  logic [CH_W-1:0]       wr_ch;
  logic [P_WIDTH-1:0]    wr_period;
  timer_mode_e           wr_mode;
  logic [P_CHANNELS-1:0] start;
  logic [P_CHANNELS-1:0] stop;
  logic [P_CHANNELS-1:0] clr;
  logic                  base_tick;
  logic [P_CHANNELS-1:0] tick;
  logic [P_CHANNELS-1:0] flag;
  logic [P_CHANNELS-1:0] busy;

  modport master (
    output wr_en, wr_ch, wr_period, wr_mode, start, stop, clr,
    input  base_tick, tick, flag, busy
  );

  modport slave (
    input  wr_en, wr_ch, wr_period, wr_mode, start, stop, clr,
    output base_tick, tick, flag, busy
  );
endinterface

// File: rtl/timer_channel.sv
// One timer channel: shadow/active period, base-tick counter, expiry tick and sticky flag.
// state   | meaning
// CH_IDLE | stopped, cnt held at 0, waiting for a start with nonzero shadow period
// CH_RUN  | counting base ticks toward the active period
module timer_channel
  import timer_pkg::*;
#(
  parameter int P_WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [P_WIDTH-1:0] wr_period,
  input  timer_mode_e        wr_mode,
  input  logic               start,
  input  logic               stop,
  input  logic               clr,
  input  logic               base_tick,
  output logic               tick,
  output logic               flag,
  output logic               busy
);

  chan_state_e        state, state_nxt;
  logic [P_WIDTH-1:0] shadow_p, active_p, cnt;
  timer_mode_e        shadow_mode, active_mode;
  logic               expire, reload, shadow_ok;

  assign shadow_ok = (shadow_p != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= CH_IDLE;
    else      state <= state_nxt;
  end

  // Stop suppresses expiry; start on an expiry cycle restarts instead of reloading/idling.
  always_comb begin
    state_nxt = state;
    expire    = 1'b0;
    reload    = 1'b0;
    unique case (state)
      CH_IDLE: begin
        if (start && shadow_ok) begin
          state_nxt = CH_RUN;
          reload    = 1'b1;
        end
      end
      CH_RUN: begin
        expire = base_tick && !stop && (cnt == active_p - 1'b1);
        if (stop) begin
          state_nxt = CH_IDLE;
        end else if (start || (expire && active_mode == MODE_PERIODIC)) begin
          reload    = shadow_ok;
          state_nxt = shadow_ok ? CH_RUN : CH_IDLE;
        end else if (expire) begin
          state_nxt = CH_IDLE;
        end
      end
      default: state_nxt = CH_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == CH_RUN);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow_p    <= '0;
      shadow_mode <= MODE_PERIODIC;
      active_p    <= '0;
      active_mode <= MODE_PERIODIC;
      cnt         <= '0;
      tick        <= 1'b0;
      flag        <= 1'b0;
    end else begin
      if (wr_en) begin
        shadow_p    <= wr_period;
        shadow_mode <= wr_mode;
      end
      if (reload) begin
        active_p    <= shadow_p;
        active_mode <= shadow_mode;
      end
      if (state_nxt == CH_IDLE || reload) cnt <= '0;
      else if (state == CH_RUN && base_tick) cnt <= cnt + 1'b1;
      tick <= expire;
      flag <= expire | (flag & ~clr);
    end
  end

endmodule

// File: rtl/timer_bank.sv
// Multi-channel programmable timer: shared prescaler plus P_CHANNELS independent channels.
module timer_bank
  import timer_pkg::*;
#(
  parameter int P_CLK_HZ   = 100_000_000,
  parameter int P_TICK_HZ  = 1_000_000,
  parameter int P_CHANNELS = 4,
  parameter int P_WIDTH    = 16
) (
  input logic         clk,
  input logic         rst,
  timer_bank_if.slave bus
);

  localparam int D      = calc_div(P_CLK_HZ, P_TICK_HZ);
  localparam int PCNT_W = (D > 1) ? $clog2(D) : 1;
  localparam int CH_W   = $clog2(P_CHANNELS);

  if (D < 1) begin : g_bad_div
    $error("timer_bank: P_CLK_HZ must be an integer multiple of P_TICK_HZ");
  end
  if (P_CHANNELS < 2) begin : g_bad_ch
    $error("timer_bank: P_CHANNELS must be at least 2");
  end

  logic [PCNT_W-1:0]     pcnt;
  logic                  base_tick;
  logic [P_CHANNELS-1:0] tick, flag, busy;

  // Registered so the pulse is clean and low during reset; D=1 yields a constant 1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pcnt      <= '0;
      base_tick <= 1'b0;
    end else begin
      base_tick <= (pcnt == PCNT_W'(D - 1));
      pcnt      <= (pcnt == PCNT_W'(D - 1)) ? '0 : pcnt + 1'b1;
    end
  end

  for (genvar i = 0; i < P_CHANNELS; i++) begin : g_ch
    timer_channel #(.P_WIDTH(P_WIDTH)) u_ch (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (bus.wr_en && (bus.wr_ch == CH_W'(i))),
      .wr_period (bus.wr_period),
      .wr_mode   (bus.wr_mode),
      .start     (bus.start[i]),
      .stop      (bus.stop[i]),
      .clr       (bus.clr[i]),
      .base_tick (base_tick),
      .tick      (tick[i]),
      .flag      (flag[i]),
      .busy      (busy[i])
    );
  end

  assign bus.base_tick = base_tick;
  assign bus.tick      = tick;
  assign bus.flag      = flag;
  assign bus.busy      = busy;

endmodule

// File: tb/tb_timer_bank.sv
// Directed bench for timer_bank with D=10, four 8-bit channels.
module tb_timer_bank;
  import timer_pkg::*;

  localparam int NCH = 4;
  localparam int W   = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  timer_bank_if #(.P_CHANNELS(NCH), .P_WIDTH(W)) bus();

  timer_bank #(
    .P_CLK_HZ  (100),
    .P_TICK_HZ (10),
    .P_CHANNELS(NCH),
    .P_WIDTH   (W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          ch;
    int          period;
    timer_mode_e mode;
    int          window;
    int          exp_first;
    int          exp_count;
    logic        exp_busy;
  } vec_t;

  vec_t vecs[5];

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic cfg(input int ch, input int p, input timer_mode_e m);
    bus.wr_en     = 1'b1;
    bus.wr_ch     = 2'(ch);
    bus.wr_period = 8'(p);
    bus.wr_mode   = m;
    step();
    bus.wr_en     = 1'b0;
  endtask

  // Returns at the negedge where base_tick is visible, so a start driven now lands on a base tick.
  task automatic sync_base();
    logic found;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (bus.base_tick) found = 1'b1;
    end
    chk("sync_base", found, 1'b1);
  endtask

  task automatic pulse_stop_clr(input int ch);
    bus.stop = NCH'(1) << ch;
    step();
    bus.stop = '0;
    bus.clr  = NCH'(1) << ch;
    step();
    bus.clr  = '0;
  endtask

  initial begin
    int first, cnt, t_idx;
    int t_at[4];
    logic any_tick, any_busy, any_flag;

    vecs[0] = '{0, 3, MODE_PERIODIC, 100, 31, 3, 1'b1};
    vecs[1] = '{1, 2, MODE_ONESHOT,  200, 21, 1, 1'b0};
    vecs[2] = '{2, 1, MODE_PERIODIC,  35, 11, 3, 1'b1};
    vecs[3] = '{3, 7, MODE_ONESHOT,  100, 71, 1, 1'b0};
    vecs[4] = '{2, 4, MODE_PERIODIC, 100, 41, 2, 1'b1};

    bus.wr_en = 1'b0; bus.wr_ch = '0; bus.wr_period = '0; bus.wr_mode = MODE_PERIODIC;
    bus.start = '0; bus.stop = '0; bus.clr = '0;

    repeat (3) step();
    chk("rst_tick", bus.tick, 0);
    chk("rst_flag", bus.flag, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_base", bus.base_tick, 0);

    rst = 1'b1;
    first = 0;
    for (int k = 1; k <= 15; k++) begin
      step();
      if (bus.base_tick && first == 0) first = k;
    end
    chk("base_first", first, 10);
    repeat (5) step();
    chk("base_period", bus.base_tick, 1);
    step();
    chk("base_width", bus.base_tick, 0);

    foreach (vecs[v]) begin
      cfg(vecs[v].ch, vecs[v].period, vecs[v].mode);
      sync_base();
      bus.start = NCH'(1) << vecs[v].ch;
      first = 0;
      cnt   = 0;
      for (int k = 1; k <= vecs[v].window; k++) begin
        step();
        if (k == 1) bus.start = '0;
        if (bus.tick[vecs[v].ch]) begin
          cnt++;
          if (first == 0) first = k;
        end
      end
      chk($sformatf("v%0d_first", v), first, vecs[v].exp_first);
      chk($sformatf("v%0d_count", v), cnt, vecs[v].exp_count);
      chk($sformatf("v%0d_busy", v), bus.busy[vecs[v].ch], vecs[v].exp_busy);
      chk($sformatf("v%0d_flag", v), bus.flag[vecs[v].ch], 1);
      bus.stop = NCH'(1) << vecs[v].ch;
      step();
      bus.stop = '0;
      chk($sformatf("v%0d_stop_busy", v), bus.busy[vecs[v].ch], 0);
      bus.clr = NCH'(1) << vecs[v].ch;
      step();
      bus.clr = '0;
      chk($sformatf("v%0d_clr_flag", v), bus.flag[vecs[v].ch], 0);
    end

    // Period rewritten mid-run: current period unchanged, next uses the new value.
    cfg(0, 3, MODE_PERIODIC);
    sync_base();
    bus.start = 4'b0001;
    t_idx = 0;
    t_at = '{0, 0, 0, 0};
    for (int k = 1; k <= 140; k++) begin
      step();
      if (k == 1) bus.start = '0;
      if (bus.tick[0] && t_idx < 4) begin
        t_at[t_idx] = k;
        t_idx++;
      end
      if (k == 15) begin
        bus.wr_en = 1'b1; bus.wr_ch = 2'd0; bus.wr_period = 8'd5; bus.wr_mode = MODE_PERIODIC;
      end
      if (k == 16) bus.wr_en = 1'b0;
    end
    chk("midwr_t0", t_at[0], 31);
    chk("midwr_t1", t_at[1], 81);
    chk("midwr_t2", t_at[2], 131);
    pulse_stop_clr(0);

    // Clear coinciding with expiry: set wins; a later clear alone works.
    cfg(0, 3, MODE_PERIODIC);
    sync_base();
    bus.start = 4'b0001;
    for (int k = 1; k <= 33; k++) begin
      step();
      if (k == 1) bus.start = '0;
      if (k == 30) chk("setclr_pre_flag", bus.flag[0], 0);
      if (k == 31) begin
        chk("setclr_tick", bus.tick[0], 1);
        chk("setclr_flag", bus.flag[0], 1);
      end
      if (k == 33) chk("clr_alone_flag", bus.flag[0], 0);
      bus.clr = (k == 30 || k == 32) ? 4'b0001 : 4'b0000;
    end
    bus.clr = '0;
    pulse_stop_clr(0);

    // Start with zero shadow period is ignored.
    cfg(2, 0, MODE_PERIODIC);
    bus.start = 4'b0100;
    step();
    bus.start = '0;
    repeat (3) step();
    chk("p0_start_busy", bus.busy[2], 0);

    // Stop and start together while running: stop wins, no tick.
    cfg(1, 2, MODE_PERIODIC);
    bus.start = 4'b0010;
    step();
    bus.start = '0;
    repeat (4) step();
    chk("ss_pre_busy", bus.busy[1], 1);
    bus.start = 4'b0010;
    bus.stop  = 4'b0010;
    step();
    bus.start = '0;
    bus.stop  = '0;
    chk("ss_busy", bus.busy[1], 0);
    cnt = 0;
    for (int k = 0; k < 60; k++) begin
      step();
      if (bus.tick[1]) cnt++;
    end
    chk("ss_no_tick", cnt, 0);

    // Start on the expiry cycle of a one-shot: tick emitted, channel keeps running.
    cfg(3, 2, MODE_ONESHOT);
    sync_base();
    bus.start = 4'b1000;
    first = 0;
    for (int k = 1; k <= 45; k++) begin
      step();
      if (k == 1) bus.start = '0;
      if (k == 21) begin
        chk("soe_tick", bus.tick[3], 1);
        chk("soe_busy", bus.busy[3], 1);
      end
      if (k > 21 && bus.tick[3] && first == 0) first = k;
      if (k == 41) chk("soe_end_busy", bus.busy[3], 0);
      bus.start = (k == 20) ? 4'b1000 : 4'b0000;
    end
    bus.start = '0;
    chk("soe_second", first, 41);
    pulse_stop_clr(3);

    // All channels running, async reset pulse mid-run.
    cfg(0, 255, MODE_PERIODIC);
    cfg(1, 1, MODE_PERIODIC);
    cfg(2, 7, MODE_PERIODIC);
    cfg(3, 3, MODE_PERIODIC);
    sync_base();
    bus.start = 4'b1111;
    for (int k = 1; k <= 31; k++) begin
      step();
      if (k == 1) bus.start = '0;
    end
    chk("all_pre_tick", bus.tick, 4'b1010);
    chk("all_pre_busy", bus.busy, 4'b1111);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_tick", bus.tick, 0);
    chk("arst_flag", bus.flag, 0);
    chk("arst_busy", bus.busy, 0);
    chk("arst_base", bus.base_tick, 0);
    step();
    step();
    rst = 1'b1;
    any_tick = 1'b0;
    any_busy = 1'b0;
    any_flag = 1'b0;
    for (int k = 0; k < 300; k++) begin
      step();
      any_tick |= |bus.tick;
      any_busy |= |bus.busy;
      any_flag |= |bus.flag;
    end
    chk("post_rst_tick", any_tick, 0);
    chk("post_rst_busy", any_busy, 0);
    chk("post_rst_flag", any_flag, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
